sumsq_to_sqrt_seq: RTL
======================

// Module: sumsq_to_sqrt_seq
// PURPOSE
//  Upstream feeder for the sequential CORDIC square-root stage: accepts a signed (x,y) pair,
//  computes x^2+y^2 with one shared shift-add squarer, rounds/saturates to unsigned Q1.(DW-1),
//  then issues a one-cycle start with data to the sqrt stage once it is idle.
//  Together the two stages form a vector-magnitude path |(x,y)|.
// PARAMETERS
//  DW  16  width of x, y and sqrt_din; inputs are signed Q1.(DW-1), output is unsigned Q1.(DW-1)
// PORTS
//  rstx       in   1   asynchronous active-low reset
//  clk        in   1   clock, rising edge
//  s_valid    in   1   input pair valid
//  s_ready    out  1   block can accept a pair (high only in IDLE)
//  x          in   DW  signed Q1.(DW-1) component
//  y          in   DW  signed Q1.(DW-1) component
//  busy       out  1   high whenever state != IDLE
//  sqrt_start out  1   one-cycle start pulse to the sqrt stage
//  sqrt_din   out  DW  unsigned Q1.(DW-1) sum of squares; stable from sqrt_start until the next accept
//  sqrt_busy  in   1   busy from the sqrt stage; low for at least the cycle in which start is sampled
// BEHAVIOUR
//  Reset values: state=IDLE, s_ready=1, busy=0, sqrt_start=0, sqrt_din=0, accumulator=0.
//  Reset mid-operation aborts immediately; no sqrt_start is issued for the aborted pair.
//  Accept: s_valid&s_ready at edge E0 captures |x|,|y| as DW-bit unsigned (|-1.0| = 2^(DW-1)).
//    Input pairs presented while s_ready=0 are not captured; upstream holds them.
//  FSM states:
//    IDLE  -> SQX on accept.
//    SQX   DW cycles: one multiplier bit per cycle, acc += |x|<<i. Then -> SQY.
//    SQY   DW cycles: acc += |y|<<i. On exit, sqrt_din <= RESULT(acc). Then -> ISSUE.
//    ISSUE sqrt_start = ~sqrt_busy (combinational from state and input).
//          When sqrt_start=1 -> IDLE; otherwise hold, with no timeout.
//  Latency: sqrt_start is asserted no earlier than 2*DW+1 cycles after E0 (33 for DW=16).
//    It is delayed one cycle for every cycle sqrt_busy stays high.
//  Throughput: at most one pair per 2*DW+2 cycles.
//    The next accept is possible in the cycle after the sqrt_start cycle.
//  Arithmetic: acc is 2*DW bits unsigned, Q2.(2DW-2); 1.0 = 2^(2DW-2); the max sum 2.0 = 2^(2DW-1) fits.
//    RESULT: r = acc[2DW-2:DW-1] (+ acc[DW-2] when rounding is enabled).
//    If acc[2DW-1]=1, or the rounding carry overflows DW bits -> saturate to all-ones.
//  sqrt_start never asserts outside ISSUE and never for more than one cycle per accepted pair.
// CONFIGURATION
//  SUMSQ_TO_SQRT_ROUND_EN defined: round half-up using acc[DW-2], saturating on carry-out.
//  Not defined: truncate, RESULT = acc[2DW-2:DW-1], with saturation only on acc[2DW-1].
// STRUCTURE
//  Shared package/include: DW default, state encoding localparams (IDLE, SQX, SQY, ISSUE),
//    and the saturation value.
//  One sub-module: serial_square_acc.
//    Shift-add step with operand register, bit counter and accumulator.
//    Reused for x then y without clearing acc.
//  The top level holds the FSM, the handshake, and RESULT rounding/saturation.
// TESTING
//  Test 1: x=0x4000, y=0x0000
//    -> sqrt_din=0x2000; sqrt_start exactly 33 cycles after accept with sqrt_busy=0.
//  Test 2: x=0x4000, y=0xC000
//    -> sqrt_din=0x4000; with the sqrt model attached, the magnitude output is ~0x5A82 (0.7071).
//  Test 3: x=0x8000, y=0x8000 (sum 2.0)
//    -> sqrt_din=0xFFFF (saturated).
//  Test 4: x=0x0080, y=0x0000 (acc=0x4000)
//    -> sqrt_din=0x0001 with ROUND_EN, 0x0000 without.
//  Test 5: hold sqrt_busy=1 for 10 cycles after SQY
//    -> sqrt_start is first asserted in the cycle sqrt_busy drops, is 1 cycle wide,
//       and s_ready stays 0 throughout.
//  Test 6: deassert rstx during SQY, then release
//    -> all outputs at reset values, no sqrt_start, and the next pair is processed correctly;
//       back-to-back s_valid is accepted only in IDLE.

Source files
------------

// File: rtl/sumsq_to_sqrt_seq_pkg.sv
// Shared definitions for the sum-of-squares feeder of the CORDIC sqrt stage:
// default data width, FSM state encoding and the saturation value.
package sumsq_to_sqrt_seq_pkg;

  localparam int SUMSQ_DW = 16;

  localparam logic [SUMSQ_DW-1:0] SUMSQ_SAT = {SUMSQ_DW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SQX   = 2'd1,
    ST_SQY   = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

endpackage

// File: rtl/sumsq_to_sqrt_seq_if.sv
// Input pair handshake for sumsq_to_sqrt_seq: the upstream (master) offers a
// signed (x,y) pair with s_valid, the feeder (slave) accepts when s_ready.
interface sumsq_to_sqrt_seq_if #(
  parameter int DW = sumsq_to_sqrt_seq_pkg::SUMSQ_DW
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] x;
  logic [DW-1:0] y;

  modport master (output s_valid, output x, output y, input s_ready);
  modport slave  (input s_valid, input x, input y, output s_ready);
endinterface

// File: rtl/sumsq_to_sqrt_seq_serial_square_acc.sv
// Serial shift-add squarer: one multiplier bit per step, adding the shifted
// operand into a 2*DW accumulator. Loading a new operand does not clear the
// accumulator unless clear_i is set, so x^2 and y^2 accumulate back to back.
// accNext_o exposes the next accumulator value from bit OUT_LSB upward so the
// caller can capture the final sum in the same cycle as the last step.
module serial_square_acc #(
  parameter int DW      = 16,
  parameter int OUT_LSB = DW - 1
) (
  input  logic                      clk,
  input  logic                      rstx,
  input  logic                      load_i,
  input  logic                      clear_i,
  input  logic                      step_i,
  input  logic [DW-1:0]             operand_i,
  output logic                      last_o,
  output logic [2*DW-1:OUT_LSB]     accNext_o
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Next-state for the accumulator, shifted operands and bit counter; a load
  // in the same cycle as a step still lets that step's addition land.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i && mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
    if (load_i) begin
      mcand_d  = {{DW{1'b0}}, operand_i};
      mplier_d = operand_i;
      cnt_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Squarer state registers.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_o    = (cnt_q == CW'(DW - 1));
  assign accNext_o = acc_d[2*DW-1:OUT_LSB];

endmodule

// File: rtl/sumsq_to_sqrt_seq.sv
// sumsq_to_sqrt_seq: accepts a signed Q1.(DW-1) pair, forms x^2+y^2 serially,
// converts to unsigned Q1.(DW-1) and hands it to the sequential sqrt stage
// with a one-cycle start once that stage is idle.
// Build option: define SUMSQ_TO_SQRT_ROUND_EN for round-half-up conversion
// (saturating on carry-out); otherwise the result is truncated.
module sumsq_to_sqrt_seq
  import sumsq_to_sqrt_seq_pkg::*;
#(
  parameter int DW = SUMSQ_DW
) (
  input  logic                    clk,
  input  logic                    rstx,
  sumsq_to_sqrt_seq_if.slave      sIf,
  output logic                    busy_o,
  output logic                    sqrt_start_o,
  output logic [DW-1:0]           sqrt_din_o,
  input  logic                    sqrt_busy_i
);

`ifdef SUMSQ_TO_SQRT_ROUND_EN
  localparam int OUT_LSB = DW - 2;
`else
  localparam int OUT_LSB = DW - 1;
`endif

  state_t                  state_q, state_d;
  logic [DW-1:0]           yAbs_q, yAbs_d;
  logic [DW-1:0]           sqrtDin_q, sqrtDin_d;
  logic [DW-1:0]           xAbs, yAbs;
  logic [DW-1:0]           operand;
  logic [DW-1:0]           result;
  logic [2*DW-1:OUT_LSB]   accNext;
  logic                    load, clear, step, last, capture, start;

  // Magnitudes as DW-bit unsigned; the most negative input maps to 2^(DW-1).
  assign xAbs = sIf.x[DW-1] ? (~sIf.x + DW'(1)) : sIf.x;
  assign yAbs = sIf.y[DW-1] ? (~sIf.y + DW'(1)) : sIf.y;

  serial_square_acc #(
    .DW      (DW),
    .OUT_LSB (OUT_LSB)
  ) uSquare (
    .clk       (clk),
    .rstx      (rstx),
    .load_i    (load),
    .clear_i   (clear),
    .step_i    (step),
    .operand_i (operand),
    .last_o    (last),
    .accNext_o (accNext)
  );

  // Convert the Q2.(2DW-2) sum to Q1.(DW-1), saturating anything >= 2.0.
`ifdef SUMSQ_TO_SQRT_ROUND_EN
  logic [DW:0] rounded;
  always_comb begin
    rounded = {1'b0, accNext[2*DW-2:DW-1]} + (DW+1)'(accNext[DW-2]);
    result  = rounded[DW-1:0];
    if (accNext[2*DW-1] || rounded[DW]) begin
      result = {DW{1'b1}};
    end
  end
`else
  always_comb begin
    result = accNext[2*DW-2:DW-1];
    if (accNext[2*DW-1]) begin
      result = {DW{1'b1}};
    end
  end
`endif

  // FSM next state and control: square x, then y into the same accumulator,
  // then wait for the sqrt stage to be idle before issuing start.
  always_comb begin
    state_d   = state_q;
    yAbs_d    = yAbs_q;
    sqrtDin_d = sqrtDin_q;
    load      = 1'b0;
    clear     = 1'b0;
    step      = 1'b0;
    capture   = 1'b0;
    start     = 1'b0;
    operand   = xAbs;
    unique case (state_q)
      ST_IDLE: begin
        if (sIf.s_valid) begin
          load    = 1'b1;
          clear   = 1'b1;
          yAbs_d  = yAbs;
          state_d = ST_SQX;
        end
      end
      ST_SQX: begin
        step = 1'b1;
        if (last) begin
          load    = 1'b1;
          operand = yAbs_q;
          state_d = ST_SQY;
        end
      end
      ST_SQY: begin
        step = 1'b1;
        if (last) begin
          capture = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start = ~sqrt_busy_i;
        if (start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      sqrtDin_d = result;
    end
  end

  // State, captured |y| and output data registers.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state_q   <= ST_IDLE;
      yAbs_q    <= '0;
      sqrtDin_q <= '0;
    end else begin
      state_q   <= state_d;
      yAbs_q    <= yAbs_d;
      sqrtDin_q <= sqrtDin_d;
    end
  end

  assign sIf.s_ready  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign sqrt_start_o = start;
  assign sqrt_din_o   = sqrtDin_q;

endmodule
